// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, requests words from synchronous instruction memory and
// buffers returned instructions with their PCs. Define FETCH_PERF_EN to add squash_count.
module fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_rd,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] squash_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FULL  = 2'd2,
        ST_REDIR = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [31:0]        pc_r;
    logic               inflight_r;
    logic [31:0]        inflight_pc_r;
    logic [31:0]        insn_mem_r [DEPTH];
    logic [31:0]        pc_mem_r   [DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;
    logic               pop_s;
    logic               push_s;
    logic               room_s;
    logic               issue_s;
    logic [OCC_W-1:0]   occ_s;

    // Handshake and occupancy: a new request needs a slot once its response lands.
    always_comb begin
        pop_s  = (count_r != CNT_W'(0)) && out_ready;
        push_s = inflight_r && !redirect;
        occ_s  = OCC_W'(count_r) + OCC_W'(inflight_r) - OCC_W'(pop_s);
        room_s = (occ_s < DEPTH_V);
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; the next state also names the mode this cycle operates in.
    always_comb begin
        state_nxt_s = ST_RUN;
        case (state_r)
            ST_BOOT: begin
                if (redirect) begin
                    state_nxt_s = ST_REDIR;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUN, ST_FULL, ST_REDIR: begin
                if (redirect) begin
                    state_nxt_s = ST_REDIR;
                end else if (room_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM outputs: issue only while running with room and no redirect.
    always_comb begin
        if (state_r == ST_BOOT) begin
            issue_s = 1'b0;
        end else begin
            issue_s = (state_nxt_s == ST_RUN);
        end
    end

    assign imem_rd   = issue_s;
    assign imem_addr = pc_r;
    assign out_valid = (count_r != CNT_W'(0));
    assign out_insn  = insn_mem_r[head_r];
    assign out_pc    = pc_mem_r[head_r];

    // Program counter: redirect wins, otherwise advance on issue (wraps naturally).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_r <= RESET_PC;
        end else if (redirect) begin
            pc_r <= redirect_target;
        end else if (issue_s) begin
            pc_r <= pc_r + 32'd1;
        end else begin
            pc_r <= pc_r;
        end
    end

    // In-flight tracker: remembers the PC whose response arrives next cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= pc_r;
            end else begin
                inflight_pc_r <= inflight_pc_r;
            end
        end
    end

    // Circular buffer of fetched instructions; redirect discards everything.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_r  <= PTR_W'(0);
            tail_r  <= PTR_W'(0);
            count_r <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                insn_mem_r[i] <= 32'h0000_0000;
                pc_mem_r[i]   <= 32'h0000_0000;
            end
        end else if (redirect) begin
            head_r  <= PTR_W'(0);
            tail_r  <= PTR_W'(0);
            count_r <= CNT_W'(0);
        end else begin
            if (push_s) begin
                insn_mem_r[tail_r] <= imem_data;
                pc_mem_r[tail_r]   <= inflight_pc_r;
                tail_r             <= tail_r + PTR_W'(1);
            end else begin
                tail_r <= tail_r;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end else begin
                head_r <= head_r;
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] squash_r;
    logic [31:0] discard_s;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // A head handshake in the redirect cycle is delivered, not squashed.
    always_comb begin
        discard_s = 32'(count_r) + 32'(inflight_r) - 32'(pop_s);
    end

    // Saturating squash counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            squash_r <= 32'h0000_0000;
        end else if (redirect) begin
            squash_r <= sat_add32(squash_r, discard_s);
        end else begin
            squash_r <= squash_r;
        end
    end

    assign squash_count = squash_r;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_rd;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_insn;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] squash_count;
`endif

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset_n(reset_n),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect(redirect), .redirect_target(redirect_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_insn(out_insn), .out_pc(out_pc)
`ifdef FETCH_PERF_EN
        , .squash_count(squash_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] pc; logic [31:0] insn; } ent_t;

    int checks = 0;
    int failures = 0;

    // reference model state
    ent_t        mq[$];
    bit          m_boot;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_pc;
    longint      m_squash;

    // responder and sample capture
    bit          last_rd;
    logic [31:0] last_addr;
    logic        s_rd, s_valid;
    logic [31:0] s_addr, s_pc, s_insn;
    logic [31:0] dq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_boot = 1'b1;
        m_pend = 1'b0;
        m_pend_pc = 32'h0;
        m_pc = 32'h0000_0000;
        m_squash = 0;
        last_rd = 1'b0;
        last_addr = 32'h0;
    endtask

    // Compare this cycle's outputs with the model, then advance the model across the edge.
    task automatic check_model();
        bit          e_valid, e_rd, pop;
        int          occ;
        e_valid = (mq.size() != 0);
        pop = e_valid && out_ready;
        occ = mq.size() + int'(m_pend) - int'(pop);
        e_rd = !m_boot && !redirect && (occ < DEPTH);
        chk("imem_rd", {31'h0, imem_rd}, {31'h0, e_rd});
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", {31'h0, out_valid}, {31'h0, e_valid});
        if (e_valid) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_insn", out_insn, mq[0].insn);
        end
`ifdef FETCH_PERF_EN
        chk("squash_count", squash_count, m_squash[31:0]);
`endif
        s_rd = imem_rd; s_addr = imem_addr; s_valid = out_valid; s_pc = out_pc; s_insn = out_insn;
        if (out_valid && out_ready) dq.push_back(out_pc);
        last_rd = imem_rd;
        last_addr = imem_addr;
        if (m_boot) begin
            m_boot = 1'b0;
            if (redirect) m_pc = redirect_target;
        end else if (redirect) begin
            m_squash = m_squash + mq.size() - int'(pop) + int'(m_pend);
            if (m_squash > 64'hFFFF_FFFF) m_squash = 64'hFFFF_FFFF;
            mq.delete();
            m_pend = 1'b0;
            m_pc = redirect_target;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_pend) mq.push_back('{m_pend_pc, m_pend_pc + 32'h100});
            m_pend = e_rd;
            m_pend_pc = m_pc;
            if (e_rd) m_pc = m_pc + 32'd1;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        check_model();
        @(posedge clock);
        #1;
        imem_data = last_rd ? last_addr + 32'h100 : $urandom();
        redirect = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic        va[8];
        logic [31:0] aa[8], pa[8], ia[8];
        logic        ra[8];
        int          nrd, mark, n5, n6, idx5;
        bit          found, prev_redir;
        logic [31:0] sq0;

        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_imem_rd", {31'h0, imem_rd}, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_insn", out_insn, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
`ifdef FETCH_PERF_EN
        chk("rst_squash", squash_count, 32'h0);
`endif

        // Stream from reset with decode always ready.
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            va[i] = s_valid; ra[i] = s_rd; aa[i] = s_addr; pa[i] = s_pc; ia[i] = s_insn;
        end
        chk("boot_no_fetch", {31'h0, ra[0]}, 32'h0);
        chk("first_valid_pre", {31'h0, va[2]}, 32'h0);
        chk("first_valid", {31'h0, va[3]}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk("stream_rd", {31'h0, ra[i+1]}, 32'h1);
            chk("stream_addr", aa[i+1], 32'(i));
            chk("stream_pc", pa[i+3], 32'(i));
            chk("stream_insn", ia[i+3], 32'h100 + 32'(i));
        end

        // Asynchronous reset mid-stream.
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("async_rst_rd", {31'h0, imem_rd}, 32'h0);
        chk("async_rst_addr", imem_addr, 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();

        // Decode stalled for 6 cycles from restart.
        out_ready = 1'b0;
        nrd = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            nrd += int'(s_rd);
        end
        chk("stall_issues", 32'(nrd), 32'd2);
        chk("stall_valid", {31'h0, s_valid}, 32'h1);
        chk("stall_head_pc", s_pc, 32'h0);
        mark = dq.size();
        out_ready = 1'b1;
        repeat (3) tick();
        chk("release_cnt", 32'(dq.size() - mark), 32'd3);
        for (int i = 0; i < 3 && mark + i < dq.size(); i++) chk("release_pc", dq[mark+i], 32'(i));

        // Redirect with a full queue and decode stalled.
        out_ready = 1'b0;
        repeat (4) tick();
`ifdef FETCH_PERF_EN
        sq0 = squash_count;
`endif
        redirect = 1'b1;
        redirect_target = 32'h40;
        tick();
`ifdef FETCH_PERF_EN
        chk("squash_delta", squash_count - sq0, 32'd2);
`endif
        out_ready = 1'b1;
        tick();
        chk("redir_rd", {31'h0, s_rd}, 32'h1);
        chk("redir_addr", s_addr, 32'h40);
        chk("redir_valid1", {31'h0, s_valid}, 32'h0);
        tick();
        chk("redir_valid2", {31'h0, s_valid}, 32'h0);
        tick();
        chk("redir_valid3", {31'h0, s_valid}, 32'h1);
        chk("redir_pc", s_pc, 32'h40);
        chk("redir_insn", s_insn, 32'h140);

        // Redirect coinciding with the handshake of pc 5.
        redirect = 1'b1;
        redirect_target = 32'd2;
        tick();
        mark = dq.size();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_valid && out_pc == 32'd5) begin
                found = 1'b1;
                redirect = 1'b1;
                redirect_target = 32'h80;
            end
            tick();
        end
        chk("pc5_seen", {31'h0, found}, 32'h1);
        repeat (4) tick();
        n5 = 0; n6 = 0; idx5 = -1;
        for (int i = mark; i < dq.size(); i++) begin
            if (dq[i] == 32'd5) begin n5++; idx5 = i; end
            if (dq[i] == 32'd6) n6++;
        end
        chk("pc5_once", 32'(n5), 32'd1);
        chk("pc6_never", 32'(n6), 32'd0);
        if (idx5 >= 0 && idx5 + 1 < dq.size()) chk("after_pc5", dq[idx5+1], 32'h80);
        else chk("after_pc5_present", 32'h0, 32'h1);

        // Wrap of the PC at the top of the address space.
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("wrap_addr0", s_addr, 32'hFFFF_FFFF);
        chk("wrap_rd0", {31'h0, s_rd}, 32'h1);
        tick();
        chk("wrap_addr1", s_addr, 32'h0);
        chk("wrap_rd1", {31'h0, s_rd}, 32'h1);
        tick();
        chk("wrap_pc0", s_pc, 32'hFFFF_FFFF);
        tick();
        chk("wrap_pc1", s_pc, 32'h0);

        // Random traffic.
        prev_redir = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if (!prev_redir && $urandom_range(0, 19) == 0) begin
                redirect = 1'b1;
                case ($urandom_range(0, 3))
                    0: redirect_target = 32'hFFFF_FFFE;
                    1: redirect_target = 32'hFFFF_FFFF;
                    default: redirect_target = $urandom();
                endcase
            end
            prev_redir = redirect;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
